// File: rtl/food_drawer.sv
// Food block renderer: erases the previous food square and draws the new one
// into the VGA framebuffer, one pixel per cycle, with a busy/done handshake.
module food_drawer #(
    parameter int         SIZE        = 2,
    parameter logic [2:0] FOOD_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       plot,
    input  logic [7:0] food_x,
    input  logic [6:0] food_y,
    output logic       busy,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_write
);

    localparam logic [2:0] LAST = 3'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

    // Write enable plus address, laid out to match {vga_write, vga_x, vga_y}.
    typedef struct packed {
        logic       wr;
        logic [7:0] x;
        logic [6:0] y;
    } pix_t;

    // Sums are one bit wider than the screen coordinates so that blocks hanging
    // off the right/bottom edge clip instead of wrapping.
    function automatic pix_t pixel(input logic [7:0] bx, input logic [6:0] by,
                                   input logic [2:0] ox, input logic [2:0] oy);
        logic [8:0] sx;
        logic [7:0] sy;
        sx = {1'b0, bx} + {6'd0, ox};
        sy = {1'b0, by} + {5'd0, oy};
        pixel.wr = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));
        pixel.x  = sx[7:0];
        pixel.y  = sy[6:0];
    endfunction

    state_t     state;
    logic [7:0] new_x, old_x, draw_x;
    logic [6:0] new_y, old_y, draw_y;
    logic       old_valid, pending;
    logic [2:0] dx, dy;

    logic       last_px;
    logic [2:0] ndx, ndy;
    pix_t       pix_food0, pix_old0, pix_new0, pix_draw0, pix_old_n, pix_draw_n;

    assign last_px = (dx == LAST) && (dy == LAST);
    assign ndx     = (dx == LAST) ? 3'd0 : dx + 3'd1;
    assign ndy     = (dx == LAST) ? dy + 3'd1 : dy;

    // Registered outputs present the pixel of the state being entered, so every
    // candidate first/next pixel is prepared here.
    assign pix_food0  = pixel(food_x, food_y, 3'd0, 3'd0);
    assign pix_old0   = pixel(old_x,  old_y,  3'd0, 3'd0);
    assign pix_new0   = pixel(new_x,  new_y,  3'd0, 3'd0);
    assign pix_draw0  = pixel(draw_x, draw_y, 3'd0, 3'd0);
    assign pix_old_n  = pixel(old_x,  old_y,  ndx,  ndy);
    assign pix_draw_n = pixel(draw_x, draw_y, ndx,  ndy);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_write  <= 1'b0;
            new_x      <= 8'd0;
            new_y      <= 7'd0;
            old_x      <= 8'd0;
            old_y      <= 7'd0;
            draw_x     <= 8'd0;
            draw_y     <= 7'd0;
            old_valid  <= 1'b0;
            pending    <= 1'b0;
            dx         <= 3'd0;
            dy         <= 3'd0;
        end else begin
            done <= 1'b0;
            if (plot) begin
                new_x <= food_x;
                new_y <= food_y;
            end
            unique case (state)
                IDLE: begin
                    if (plot) begin
                        busy <= 1'b1;
                        dx   <= 3'd0;
                        dy   <= 3'd0;
                        if (old_valid) begin
                            state                       <= ERASE;
                            {vga_write, vga_x, vga_y}   <= pix_old0;
                            vga_colour                  <= BG_COLOUR;
                        end else begin
                            state                       <= DRAW;
                            draw_x                      <= food_x;
                            draw_y                      <= food_y;
                            {vga_write, vga_x, vga_y}   <= pix_food0;
                            vga_colour                  <= FOOD_COLOUR;
                        end
                    end
                end
                ERASE: begin
                    if (plot) pending <= 1'b1;
                    if (last_px) begin
                        // Snapshot so later plots only affect the follow-up sequence.
                        state                     <= DRAW;
                        dx                        <= 3'd0;
                        dy                        <= 3'd0;
                        draw_x                    <= new_x;
                        draw_y                    <= new_y;
                        {vga_write, vga_x, vga_y} <= pix_new0;
                        vga_colour                <= FOOD_COLOUR;
                    end else begin
                        dx                        <= ndx;
                        dy                        <= ndy;
                        {vga_write, vga_x, vga_y} <= pix_old_n;
                    end
                end
                DRAW: begin
                    if (plot) pending <= 1'b1;
                    if (last_px) begin
                        state     <= FINISH;
                        dx        <= 3'd0;
                        dy        <= 3'd0;
                        vga_write <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        dx                        <= ndx;
                        dy                        <= ndy;
                        {vga_write, vga_x, vga_y} <= pix_draw_n;
                    end
                end
                FINISH: begin
                    old_x     <= draw_x;
                    old_y     <= draw_y;
                    old_valid <= 1'b1;
                    if (pending || plot) begin
                        // The block just drawn becomes the one to erase.
                        pending                   <= 1'b0;
                        state                     <= ERASE;
                        {vga_write, vga_x, vga_y} <= pix_draw0;
                        vga_colour                <= BG_COLOUR;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_food_drawer.sv
// Self-checking bench for food_drawer: table of single plots plus hand-written
// multi-cycle sequences, with a pixel scoreboard fed by a small reference model.
module tb_food_drawer;

    localparam int         SIZE = 2;
    localparam logic [2:0] FOOD = 3'b100;
    localparam logic [2:0] BG   = 3'b000;

    logic       clock = 1'b0;
    logic       reset, plot;
    logic [7:0] food_x;
    logic [6:0] food_y;
    logic       busy, done, vga_write;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    food_drawer dut (
        .clock(clock), .reset(reset), .plot(plot), .food_x(food_x), .food_y(food_y),
        .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_write(vga_write)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } px_t;

    typedef struct {
        int x;
        int y;
        int len;   // cycles from plot acceptance to done
        int nwr;   // visible (unclipped) writes
    } vec_t;

    px_t exp_q[$];
    int  checks = 0, errors = 0;
    int  n_writes = 0, n_done = 0;
    int  m_old_x, m_old_y;
    bit  m_old_v;

    // Pixel scoreboard: every write must match the next expected pixel.
    always @(negedge clock) begin
        if (vga_write === 1'b1) begin
            px_t e;
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel: unexpected write at (%0d,%0d) colour %0d", vga_x, vga_y, vga_colour);
            end else begin
                e = exp_q.pop_front();
                if ({vga_x, vga_y, vga_colour} !== e) begin
                    errors++;
                    $display("FAIL pixel: got (%0d,%0d) colour %0d, expected (%0d,%0d) colour %0d",
                             vga_x, vga_y, vga_colour, e.x, e.y, e.c);
                end
            end
        end
        if (done === 1'b1) n_done++;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_block(input int bx, input int by, input logic [2:0] c);
        for (int yy = 0; yy < SIZE; yy++)
            for (int xx = 0; xx < SIZE; xx++)
                if (bx + xx < 160 && by + yy < 120)
                    exp_q.push_back({8'(bx + xx), 7'(by + yy), c});
    endtask

    task automatic push_plot(input int nx, input int ny);
        if (m_old_v) push_block(m_old_x, m_old_y, BG);
        push_block(nx, ny, FOOD);
        m_old_x = nx;
        m_old_y = ny;
        m_old_v = 1'b1;
    endtask

    task automatic wait_done(input int base, input int n, input int budget, output int cyc);
        cyc = 0;
        while (n_done - base < n && cyc < budget) begin
            tick();
            cyc++;
        end
        if (n_done - base < n) chk("done pulse timeout", n_done - base, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        plot  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        m_old_v = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_plot(input vec_t v, input string nm);
        int w0, d0, cyc;
        push_plot(v.x, v.y);
        w0 = n_writes;
        d0 = n_done;
        plot   = 1'b1;
        food_x = 8'(v.x);
        food_y = 7'(v.y);
        tick();
        plot = 1'b0;
        chk({nm, " busy after plot"}, busy, 1);
        wait_done(d0, 1, 40, cyc);
        chk({nm, " latency"}, cyc, v.len);
        tick();
        chk({nm, " busy after done"}, busy, 0);
        chk({nm, " done width"}, done, 0);
        chk({nm, " write count"}, n_writes - w0, v.nwr);
        chk({nm, " queue drained"}, exp_q.size(), 0);
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v1;
        int   w0, d0, cyc;

        tbl[0] = '{10,  20,  4, 4};   // first draw skips erase
        tbl[1] = '{50,  60,  8, 8};
        tbl[2] = '{159, 119, 8, 5};   // three pixels clipped
        tbl[3] = '{0,   0,   8, 5};
        tbl[4] = '{158, 118, 8, 8};   // exactly fits
        tbl[5] = '{255, 127, 8, 4};   // fully off-screen
        tbl[6] = '{100, 5,   8, 4};   // erase of off-screen block writes nothing

        food_x = 8'd0;
        food_y = 7'd0;
        do_reset();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset vga_write", vga_write, 0);
        chk("reset vga_x", vga_x, 0);
        chk("reset vga_y", vga_y, 0);
        chk("reset vga_colour", vga_colour, 0);

        for (int i = 0; i < 7; i++)
            run_plot(tbl[i], $sformatf("vec%0d", i));

        // Two plots during DRAW: one follow-up sequence with the last coordinates.
        push_plot(50, 60);
        w0 = n_writes;
        d0 = n_done;
        plot = 1'b1; food_x = 8'd50; food_y = 7'd60;
        tick();
        plot = 1'b0;
        repeat (4) tick();
        plot = 1'b1; food_x = 8'd5; food_y = 7'd5;
        tick();
        food_x = 8'd7; food_y = 7'd7;
        tick();
        plot = 1'b0;
        push_plot(7, 7);
        wait_done(d0, 2, 60, cyc);
        chk("pending two done pulses", n_done - d0, 2);
        chk("pending latency", cyc, 11);
        tick();
        chk("pending busy after done", busy, 0);
        chk("pending write count", n_writes - w0, 16);
        chk("pending queue drained", exp_q.size(), 0);

        // Reset during ERASE abandons the sequence; next draw skips erase.
        w0 = n_writes;
        exp_q.push_back({8'd7, 7'd7, BG});
        exp_q.push_back({8'd8, 7'd7, BG});
        plot = 1'b1; food_x = 8'd20; food_y = 7'd30;
        tick();
        plot = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("midreset vga_write", vga_write, 0);
        chk("midreset busy", busy, 0);
        reset = 1'b0;
        m_old_v = 1'b0;
        chk("midreset partial writes", n_writes - w0, 2);
        chk("midreset queue drained", exp_q.size(), 0);
        v1 = '{1, 1, 4, 4};
        run_plot(v1, "after reset");

        // plot held high across a FINISH: exactly two back-to-back sequences.
        push_plot(30, 40);
        push_plot(30, 40);
        w0 = n_writes;
        d0 = n_done;
        plot = 1'b1; food_x = 8'd30; food_y = 7'd40;
        repeat (10) tick();
        plot = 1'b0;
        chk("held first done", n_done - d0, 1);
        chk("held busy across finish", busy, 1);
        wait_done(d0, 2, 40, cyc);
        chk("held second done latency", cyc, 8);
        tick();
        chk("held busy after done", busy, 0);
        chk("held write count", n_writes - w0, 16);
        chk("held queue drained", exp_q.size(), 0);
        repeat (3) tick();
        chk("held no extra done", n_done - d0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
